// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared types and sizing helpers for the input conditioner
package input_conditioner_pkg;

    // Debounce FSM states: two stable levels, each with a qualification state
    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        WAIT_HI = 2'd1,
        ST_HI   = 2'd2,
        WAIT_LO = 2'd3
    } cond_state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Counter width for a debounce window, never narrower than one bit
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_bit_sync.sv
// rtl/input_conditioner_bit_sync.sv - multi-flop synchroniser for one asynchronous bit
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw bit through the chain; only the last stage is safe to use
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise and debounce one raw input into a clean level with edge strobes
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic vint,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              w_s;
    cond_state_t       r_state;
    cond_state_t       w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic              r_vint;
    logic              w_vint_nx;
    logic              r_rise;
    logic              w_rise_nx;
    logic              r_fall;
    logic              w_fall_nx;
    logic              r_busy;
    logic              w_busy_nx;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     (din),
        .o_q     (w_s)
    );

    // Next-state logic: a new level must persist for the whole window before it is committed
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_vint_nx  = r_vint;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        case (r_state)
            ST_LO: begin
                if (w_s) begin
                    w_state_nx = WAIT_HI;
                    w_cnt_nx   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!w_s) begin
                    w_state_nx = ST_LO;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_HI;
                    w_vint_nx  = 1'b1;
                    w_rise_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!w_s) begin
                    w_state_nx = WAIT_LO;
                    w_cnt_nx   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (w_s) begin
                    w_state_nx = ST_HI;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_LO;
                    w_vint_nx  = 1'b0;
                    w_fall_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = ST_LO;
                w_cnt_nx   = '0;
                w_vint_nx  = 1'b0;
            end
        endcase
        w_busy_nx = (w_state_nx == WAIT_HI) || (w_state_nx == WAIT_LO);
    end

    // State, counter and all outputs are registered so downstream sees glitch-free levels
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_vint  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_vint  <= w_vint_nx;
            r_rise  <= w_rise_nx;
            r_fall  <= w_fall_nx;
            r_busy  <= w_busy_nx;
        end
    end

    assign vint = r_vint;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic clock;
    logic reset_n;
    logic din;
    logic vint;
    logic rise;
    logic fall;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    input_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (din),
        .vint    (vint),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic er,
                           input logic ef, input logic eb);
        chk({tag, ".vint"}, vint, ev);
        chk({tag, ".rise"}, rise, er);
        chk({tag, ".fall"}, fall, ef);
        chk({tag, ".busy"}, busy, eb);
    endtask

    // Drive din for the coming edge, clock it, then check all outputs
    task automatic step(input logic d, input logic ev, input logic er,
                        input logic ef, input logic eb, input string tag);
        din = d;
        tick();
        chk_all(tag, ev, er, ef, eb);
    endtask

    initial begin
        reset_n = 1'b0;
        din     = 1'b1;

        // Reset held with din high: everything stays low
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_all($sformatf("in_reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset_n = 1'b1;

        // Release with din=1: rise at edge 6
        for (int i = 1; i <= 8; i++)
            step(1'b1, i >= 6, i == 6, 1'b0, (i >= 3) && (i <= 5),
                 $sformatf("rst_rel%0d", i));

        // Return low: fall at edge 6
        for (int i = 1; i <= 8; i++)
            step(1'b0, i <= 5, 1'b0, i == 6, (i >= 3) && (i <= 5),
                 $sformatf("go_low%0d", i));

        // Clean step held 20 cycles
        for (int i = 1; i <= 20; i++)
            step(1'b1, i >= 6, i == 6, 1'b0, (i >= 3) && (i <= 5),
                 $sformatf("clean%0d", i));

        for (int i = 1; i <= 8; i++)
            step(1'b0, i <= 5, 1'b0, i == 6, (i >= 3) && (i <= 5),
                 $sformatf("clean_low%0d", i));

        // Glitch of 3 cycles: busy pulses, level never moves
        for (int i = 1; i <= 12; i++)
            step(i <= 3, 1'b0, 1'b0, 1'b0, (i >= 3) && (i <= 5),
                 $sformatf("glitch%0d", i));

        // Exactly 4 cycles high: rise at 6, fall at 10
        for (int i = 1; i <= 14; i++)
            step(i <= 4, (i >= 6) && (i <= 9), i == 6, i == 10,
                 ((i >= 3) && (i <= 5)) || ((i >= 7) && (i <= 9)),
                 $sformatf("thresh%0d", i));

        // Bounce 1,0,1,0,1 then hold 1: single rise at edge 10
        for (int i = 1; i <= 14; i++)
            step((i >= 5) || (i == 1) || (i == 3), i >= 10, i == 10, 1'b0,
                 (i == 3) || (i == 5) || ((i >= 7) && (i <= 9)),
                 $sformatf("bounce%0d", i));

        // Start a fall qualification, then reset in the middle of it
        for (int i = 1; i <= 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, i == 3, $sformatf("midq%0d", i));
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk_all($sformatf("midq_hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 10; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("midq_after%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
